adc_capture_sequencer: RTL and testbench

Sequences one acquisition cycle of the ADC-to-PC path: waits for arm, captures a fixed-length record of 14-bit ADC samples into a waveform buffer, then drops `acquire` so the downstream UART serializer ships the record, and holds the buffer stable until the transmit window ends. It sits between the ADC sample interface and the serializer, and is the only driver of the serializer's `acquire` input and `waveform` array.

---
 rtl/adc_capture_if.sv | 27 ++
 rtl/adc_capture_sequencer.sv | 156 +++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_if.sv
// ADC sample stream, control levels and capture outputs shared by the sequencer and its
// neighbours: slave = the sequencer, master = the sample source / controller side.
interface adc_capture_if #(
  parameter int N_SAMPLES = 32,
  parameter int SAMPLE_W  = 14
);
  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_valid;
  logic                arm;
  logic                continuous;
  logic [SAMPLE_W-1:0] threshold;
  logic [SAMPLE_W-1:0] waveform [N_SAMPLES];
  logic                acquire;
  logic                busy;
  logic [2:0]          state;
  logic [15:0]         record_count;

  modport master (
    output adc_data, adc_valid, arm, continuous, threshold,
    input  waveform, acquire, busy, state, record_count
  );

  modport slave (
    input  adc_data, adc_valid, arm, continuous, threshold,
    output waveform, acquire, busy, state, record_count
  );
endinterface

// File: rtl/adc_capture_sequencer.sv
// One ADC acquisition cycle: arm, trigger, capture a fixed record, hold it for the serializer.
// Optional macro ADC_THRESH_TRIG_EN selects a rising-crossing threshold trigger.
module adc_capture_sequencer #(
  parameter int N_SAMPLES      = 32,
  parameter int SAMPLE_W       = 14,
  parameter int SEND_CYCLES    = 962,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  adc_capture_if.slave cap_if
);
  localparam int IDX_W   = $clog2(N_SAMPLES);
  localparam int CNT_MAX = (SEND_CYCLES > HOLDOFF_CYCLES) ? SEND_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] SEND_LOAD = CNT_W'(SEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         rc_q, rc_d;
  logic                acquire_q, acquire_d;
  logic                busy_q;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic                trig;
  logic [SAMPLE_W-1:0] wave_q [N_SAMPLES];

`ifdef ADC_THRESH_TRIG_EN
  // Previous valid sample seen in WAIT_TRIG; all-ones on entry so the first sample cannot trigger.
  logic [SAMPLE_W-1:0] prev_q, prev_d;

  assign trig = cap_if.adc_valid && (cap_if.adc_data >= cap_if.threshold)
                && (prev_q < cap_if.threshold);

  always_comb begin
    prev_d = prev_q;
    if (state_d == S_WAIT && state_q != S_WAIT) begin
      prev_d = '1;
    end else if (state_q == S_WAIT && cap_if.adc_valid) begin
      prev_d = cap_if.adc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= '1;
    else        prev_q <= prev_d;
  end
`else
  logic unused_threshold;

  assign trig             = cap_if.adc_valid;
  assign unused_threshold = ^cap_if.threshold;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rc_d      = rc_q;
    acquire_d = acquire_q;
    wr_en     = 1'b0;
    wr_idx    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (cap_if.arm) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (trig) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          idx_d   = IDX_W'(1);
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (cap_if.adc_valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            cnt_d     = SEND_LOAD;
            acquire_d = 1'b0;
            state_d   = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (cnt_q == '0) begin
          rc_d      = rc_q + 16'd1;
          acquire_d = 1'b1;
          if (cap_if.continuous) begin
            cnt_d   = HOLD_LOAD;
            state_d = S_HOLDOFF;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) state_d = cap_if.continuous ? S_WAIT : S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d   = S_IDLE;
        acquire_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rc_q      <= '0;
      acquire_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rc_q      <= rc_d;
      acquire_q <= acquire_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // Per-entry registers so reset can clear the whole record in one edge.
  for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_wave
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wave_q[gi] <= '0;
      end else if (wr_en && wr_idx == IDX_W'(gi)) begin
        wave_q[gi] <= cap_if.adc_data;
      end
    end
  end

  assign cap_if.waveform     = wave_q;
  assign cap_if.acquire      = acquire_q;
  assign cap_if.busy         = busy_q;
  assign cap_if.state        = state_q;
  assign cap_if.record_count = rc_q;
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomized bench for adc_capture_sequencer: stimulus is pre-generated, an event-level model
// derives the expected state/acquire/count/waveform trace, and the DUT is compared every cycle.
module tb_adc_capture_sequencer;
  localparam int N    = 32;
  localparam int SW   = 14;
  localparam int SC   = 962;
  localparam int HC   = 1000;
  localparam int MAXE = 5600;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_capture_if #(.N_SAMPLES(N), .SAMPLE_W(SW)) bus ();

  adc_capture_sequencer #(
    .N_SAMPLES(N), .SAMPLE_W(SW), .SEND_CYCLES(SC), .HOLDOFF_CYCLES(HC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap_if (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus per edge (index = edge number after the reset preamble)
  bit st_v [MAXE+1];
  int st_d [MAXE+1];
  bit st_c [MAXE+1];
  int thr, arm_len, n_edges, rst_edge;

  // expected trace per edge
  int ex_state [MAXE+1];
  int ex_rc    [MAXE+1];
  int wr_idx   [MAXE+1];
  int first_s, m_lim;

  // DUT-measured results of the last scenario
  int last_first_low, last_low_edges;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic gen(input int n, input int vmode, input int dmode, input int cont_drop);
    int ds2 [4];
    int ds3 [4];
    ds2 = '{'h1000, 'h1FFF, 'h2000, 'h2100};
    ds3 = '{'h3000, 'h3100, 'h1000, 'h2500};
    n_edges  = n;
    rst_edge = -1;
    for (int e = 0; e <= n; e++) begin
      case (vmode)
        0:       st_v[e] = 1'b1;
        1:       st_v[e] = (e % 2) == 1;
        default: st_v[e] = ($urandom % 10) < 6;
      endcase
      case (dmode)
        0: st_d[e] = 100 + e - 2;
        1: st_d[e] = int'($urandom % (1 << SW));
        2: st_d[e] = (e >= 2 && e <= 5) ? ds2[e-2] : (('h2200 + e) & 'h3FFF);
        default: st_d[e] = (e >= 2 && e <= 5) ? ds3[e-2] : (('h2600 + e) & 'h3FFF);
      endcase
      st_c[e] = (e < cont_drop);
    end
  endtask

  task automatic fill(input int a, input int b, input int val);
    for (int e = a; e <= b && e <= m_lim; e++) ex_state[e] = val;
  endtask

  // Walks the records one at a time: find trigger, the next N valid samples, then fixed windows.
  task automatic build_model();
    int w, t, s, x, h, k, acc;
    bit below;
    m_lim   = (rst_edge > 0) ? rst_edge - 1 : n_edges;
    first_s = -1;
    for (int e = 0; e <= n_edges; e++) begin
      ex_state[e] = 0;
      ex_rc[e]    = 0;
      wr_idx[e]   = -1;
    end
    w = 1;
    while (1) begin
      t = -1;
      below = 1'b0;
      for (int e = w + 1; e <= m_lim; e++) begin
        if (st_v[e]) begin
`ifdef ADC_THRESH_TRIG_EN
          if (st_d[e] >= thr && below) begin t = e; break; end
          below = (st_d[e] < thr);
`else
          t = e;
          break;
`endif
        end
      end
      if (t < 0) begin fill(w, m_lim, 1); break; end
      fill(w, t - 1, 1);
      s = -1;
      k = 0;
      for (int e = t; e <= m_lim; e++) begin
        if (st_v[e]) begin
          wr_idx[e] = k;
          k++;
          if (k == N) begin s = e; break; end
        end
      end
      if (s < 0) begin fill(t, m_lim, 2); break; end
      if (first_s < 0) first_s = s;
      fill(t, s - 1, 2);
      x = s + SC;
      fill(s, x - 1, 3);
      if (x > m_lim) break;
      ex_rc[x] = ex_rc[x] + 1;
      if (!st_c[x]) break;
      h = x + HC;
      fill(x, h - 1, 4);
      if (h > m_lim) break;
      if (!st_c[h]) break;
      w = h;
    end
    acc = 0;
    for (int e = 0; e <= n_edges; e++) begin
      if (e == rst_edge) acc = 0;
      acc = (acc + ex_rc[e]) % 65536;
      ex_rc[e] = acc;
    end
  endtask

  task automatic run_scn(input string name);
    int exp_wf [N];
    int m_state, m_acq, m_busy, m_rc, m_wf, nz, recs;
    m_state = 0; m_acq = 0; m_busy = 0; m_rc = 0; m_wf = 0; nz = 0;
    last_first_low = -1;
    last_low_edges = 0;
    for (int i = 0; i < N; i++) exp_wf[i] = 0;

    // reset preamble with arm asserted: arm must not leak through reset
    rst_n = 1'b0;
    bus.arm = 1'b1; bus.adc_valid = 1'b1; bus.adc_data = 14'h3FFF;
    bus.continuous = 1'b1; bus.threshold = SW'(thr);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (bus.waveform[i] != '0) nz++;
    chk({name, "/reset_acquire"}, int'(bus.acquire), 1);
    chk({name, "/reset_busy"}, int'(bus.busy), 0);
    chk({name, "/reset_state"}, int'(bus.state), 0);
    chk({name, "/reset_record_count"}, int'(bus.record_count), 0);
    chk({name, "/reset_waveform_nonzero"}, nz, 0);

    for (int e = 1; e <= n_edges; e++) begin
      rst_n          = (e != rst_edge);
      bus.arm        = (e <= arm_len);
      bus.adc_valid  = st_v[e];
      bus.adc_data   = SW'(st_d[e]);
      bus.continuous = st_c[e];
      @(posedge clk);
      #1;
      if (e == rst_edge) begin
        for (int i = 0; i < N; i++) exp_wf[i] = 0;
      end else if (wr_idx[e] >= 0) begin
        exp_wf[wr_idx[e]] = st_d[e];
      end
      if (int'(bus.state) != ex_state[e]) m_state++;
      if (int'(bus.acquire) != ((ex_state[e] == 3) ? 0 : 1)) m_acq++;
      if (int'(bus.busy) != ((ex_state[e] != 0) ? 1 : 0)) m_busy++;
      if (int'(bus.record_count) != ex_rc[e]) m_rc++;
      for (int i = 0; i < N; i++) if (int'(bus.waveform[i]) != exp_wf[i]) m_wf++;
      if (bus.acquire == 1'b0) begin
        last_low_edges++;
        if (last_first_low < 0) last_first_low = e;
      end
    end
    rst_n = 1'b1;
    chk({name, "/state_trace_mismatches"}, m_state, 0);
    chk({name, "/acquire_trace_mismatches"}, m_acq, 0);
    chk({name, "/busy_trace_mismatches"}, m_busy, 0);
    chk({name, "/record_count_trace_mismatches"}, m_rc, 0);
    chk({name, "/waveform_trace_mismatches"}, m_wf, 0);
    chk({name, "/first_acquire_low_edge"}, last_first_low, first_s);
    recs = ex_rc[n_edges];
    $display("scenario %s: edges=%0d send_entry=%0d acquire_low_cycles=%0d records=%0d",
             name, n_edges, last_first_low, last_low_edges, int'(bus.record_count));
    chk({name, "/final_record_count"}, int'(bus.record_count), recs);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.arm = 1'b0; bus.adc_valid = 1'b0; bus.adc_data = '0;
    bus.continuous = 1'b0; bus.threshold = '0;

    // free-run: valid held high, ramp from 100
    thr = 110; arm_len = 1;
    gen(1100, 0, 0, 0); build_model(); run_scn("free_run");
    chk("free_run/acquire_low_cycles", last_low_edges, SC);
    chk("free_run/final_state", int'(bus.state), 0);
`ifndef ADC_THRESH_TRIG_EN
    chk("free_run/waveform0", int'(bus.waveform[0]), 100);
    chk("free_run/waveform31", int'(bus.waveform[N-1]), 100 + N - 1);
    chk("free_run/acquire_fall_latency", last_first_low - 1, N);
`else
    chk("free_run/waveform0", int'(bus.waveform[0]), 110);
`endif

    // stall: valid every other cycle, arm held through WAIT_TRIG
    thr = $urandom_range('h1000, 'h3000); arm_len = 5;
    gen(1150, 1, 1, 0); build_model(); run_scn("stall");
`ifndef ADC_THRESH_TRIG_EN
    chk("stall/capture_span", last_first_low - 1, 2 * N);
`endif

    // random valid pattern and data
    thr = $urandom_range('h1000, 'h3000); arm_len = 2;
    gen(1300, 2, 1, 0); build_model(); run_scn("random");

    // directed rising crossing
    thr = 'h2000; arm_len = 1;
    gen(1050, 0, 2, 0); build_model(); run_scn("crossing");
`ifdef ADC_THRESH_TRIG_EN
    chk("crossing/waveform0", int'(bus.waveform[0]), 'h2000);
    chk("crossing/waveform1", int'(bus.waveform[1]), 'h2100);
`else
    chk("crossing/waveform0", int'(bus.waveform[0]), 'h1000);
`endif

    // first sample already above threshold must not trigger
    gen(1050, 0, 3, 0); build_model(); run_scn("above_first");
`ifdef ADC_THRESH_TRIG_EN
    chk("above_first/waveform0", int'(bus.waveform[0]), 'h2500);
`else
    chk("above_first/waveform0", int'(bus.waveform[0]), 'h3000);
`endif

    // continuous mode, dropped during the third record
    thr = $urandom_range('h1000, 'h3000); arm_len = 1;
    gen(5300, 1, 1, 4600); build_model(); run_scn("continuous");
`ifndef ADC_THRESH_TRIG_EN
    chk("continuous/record_count", int'(bus.record_count), 3);
`endif

    // reset 400 cycles into SEND
    thr = $urandom_range('h1000, 'h3000); arm_len = 1;
    gen(MAXE, 0, 1, 0); build_model();
    if (first_s > 0 && first_s + 440 <= MAXE) begin
      rst_edge = first_s + 400;
      n_edges  = rst_edge + 40;
    end
    build_model(); run_scn("reset_in_send");
    chk("reset_in_send/acquire_after", int'(bus.acquire), 1);
    chk("reset_in_send/state_after", int'(bus.state), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
